// File: rtl/shiftreg_elastic_pkg.sv
// Shared defaults for the elastic shift register slice.
package shiftreg_elastic_pkg;

  localparam int unsigned SRE_D_WIDTH_DEF = 6;
  localparam int unsigned SRE_DEPTH_DEF   = 4;

endpackage

// File: rtl/shiftreg_elastic_stage.sv
// One valid/ready register stage: holds a word until its successor can take it.
module shiftreg_elastic_stage
  import shiftreg_elastic_pkg::*;
#(
  parameter int unsigned D_WIDTH = SRE_D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data,
  input  logic               out_ready
);

  logic               valid_q;
  logic [D_WIDTH-1:0] data_q;

  // An empty stage always accepts; a full one only if it drains this cycle.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Valid flag: cleared by reset or clear, otherwise follows the source when ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
    end
  end

  // Payload register: no reset, loaded only on an actual transfer.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/shiftreg_elastic.sv
// Bubble-collapsing valid/ready pipeline of DEPTH stages with flush and occupancy.
module shiftreg_elastic
  import shiftreg_elastic_pkg::*;
#(
  parameter  int unsigned D_WIDTH = SRE_D_WIDTH_DEF,
  parameter  int unsigned DEPTH   = SRE_DEPTH_DEF,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [CNT_W-1:0]   occupancy,
  output logic               empty,
  output logic               full
);

  // Reset or flush blocks both ports so no word enters or leaves while clearing.
  logic             kill;
  logic [DEPTH-1:0] vld_vec;

  assign kill = rst | flush;

  // Each stage keeps its ready/valid/data in its own generate scope so the
  // ready chain is a set of distinct nets rather than bits of one vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic               in_rdy;
    logic               nxt_rdy;
    logic               src_vld;
    logic [D_WIDTH-1:0] src_dat;
    logic               vld;
    logic [D_WIDTH-1:0] dat;

    if (i == 0) begin : g_head
      assign src_vld = up_valid & ~kill;
      assign src_dat = up_data;
    end else begin : g_body
      assign src_vld = g_stage[i-1].vld;
      assign src_dat = g_stage[i-1].dat;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign nxt_rdy = down_ready & ~kill;
    end else begin : g_mid
      assign nxt_rdy = g_stage[i+1].in_rdy;
    end

    shiftreg_elastic_stage #(
      .D_WIDTH(D_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .in_valid (src_vld),
      .in_data  (src_dat),
      .in_ready (in_rdy),
      .out_valid(vld),
      .out_data (dat),
      .out_ready(nxt_rdy)
    );

    assign vld_vec[i] = vld;
  end

  assign up_ready   = g_stage[0].in_rdy & ~kill;
  assign down_valid = g_stage[DEPTH-1].vld & ~kill;
  assign down_data  = g_stage[DEPTH-1].dat;

  // Occupancy is the popcount of the stage valid registers.
  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CNT_W'(vld_vec[i]);
    end
  end

  assign empty = (occupancy == '0);
  assign full  = (occupancy == CNT_W'(DEPTH));

endmodule

// File: tb/tb_shiftreg_elastic.sv
// Self-checking bench for shiftreg_elastic (DEPTH=4, D_WIDTH=6).
module tb_shiftreg_elastic;

  localparam int unsigned DW    = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst, flush, up_valid, up_ready, down_valid, down_ready, empty, full;
  logic [DW-1:0] up_data, down_data;
  logic [CW-1:0] occupancy;

  always #5 clk = ~clk;

  shiftreg_elastic #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
    .occupancy(occupancy), .empty(empty), .full(full)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ordered list of words, each with its stage position.
  typedef struct {
    logic [DW-1:0] data;
    int            pos;
  } word_t;
  word_t mq[$];

  bit            chk_en;
  logic          obs_ur, obs_dv, obs_empty, obs_full;
  logic [DW-1:0] obs_dd;
  int            obs_occ;
  bit            last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then advance the model.
  task automatic step(input logic r, input logic f, input logic uv,
                      input logic [DW-1:0] ud, input logic dr);
    bit   m_full, m_ur, m_dv, acc, pop;
    int   limit, np;
    @(negedge clk);
    rst = r; flush = f; up_valid = uv; up_data = ud; down_ready = dr;
    #1;
    m_full = (mq.size() == DEPTH);
    m_ur   = !f && (!m_full || dr);
    m_dv   = !r && !f && (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
    obs_ur = up_ready; obs_dv = down_valid; obs_dd = down_data;
    obs_occ = int'(occupancy); obs_empty = empty; obs_full = full;
    if (chk_en) begin
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(m_full));
      chk("down_valid", 32'(down_valid), 32'(m_dv));
      if (m_dv) chk("down_data", 32'(down_data), 32'(mq[0].data));
      if (!r) chk("up_ready", 32'(up_ready), 32'(m_ur));
    end
    acc = !r && uv && m_ur;
    pop = m_dv && dr;
    last_acc = acc;
    @(posedge clk);
    if (r || f) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      limit = DEPTH;
      for (int i = 0; i < mq.size(); i++) begin
        np = (mq[i].pos + 1 < limit - 1) ? mq[i].pos + 1 : limit - 1;
        mq[i].pos = np;
        limit = np;
      end
      if (acc) mq.push_back('{data: ud, pos: 0});
    end
  endtask

  typedef struct {
    logic          uv;
    logic [DW-1:0] ud;
    logic          dr;
    logic          ur;
    logic          dv;
    logic [DW-1:0] dd;
    int            occ;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int acc_cyc, first_out, last_out, nxt;

    // Bubble collapse then drain, starting from empty.
    tbl[0]  = '{1'b1, 6'h0A, 1'b0, 1'b1, 1'b0, 6'h00, 0};
    tbl[1]  = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 6'h00, 1};
    tbl[2]  = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 6'h00, 1};
    tbl[3]  = '{1'b1, 6'h0B, 1'b0, 1'b1, 1'b0, 6'h00, 1};
    tbl[4]  = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h0A, 2};
    tbl[5]  = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h0A, 2};
    tbl[6]  = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h0A, 2};
    tbl[7]  = '{1'b1, 6'h0C, 1'b0, 1'b1, 1'b1, 6'h0A, 2};
    tbl[8]  = '{1'b1, 6'h0D, 1'b0, 1'b1, 1'b1, 6'h0A, 3};
    tbl[9]  = '{1'b1, 6'h0E, 1'b0, 1'b0, 1'b1, 6'h0A, 4};
    tbl[10] = '{1'b1, 6'h0E, 1'b1, 1'b1, 1'b1, 6'h0A, 4};
    tbl[11] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h0B, 4};
    tbl[12] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h0C, 3};
    tbl[13] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h0D, 2};
    tbl[14] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 6'h0E, 1};
    tbl[15] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 6'h00, 0};

    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
    chk_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("post_reset_occ", 32'(obs_occ), 32'd0);
    chk("post_reset_empty", 32'(obs_empty), 32'd1);
    chk("post_reset_up_ready", 32'(obs_ur), 32'd1);

    // Table-driven bubble collapse
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, tbl[i].uv, tbl[i].ud, tbl[i].dr);
      chk($sformatf("tbl%0d_up_ready", i), 32'(obs_ur), 32'(tbl[i].ur));
      chk($sformatf("tbl%0d_down_valid", i), 32'(obs_dv), 32'(tbl[i].dv));
      if (tbl[i].dv) chk($sformatf("tbl%0d_down_data", i), 32'(obs_dd), 32'(tbl[i].dd));
      chk($sformatf("tbl%0d_occ", i), 32'(obs_occ), 32'(tbl[i].occ));
      chk($sformatf("tbl%0d_full", i), 32'(obs_full), 32'(tbl[i].occ == DEPTH));
    end

    // Latency and back-to-back throughput
    acc_cyc = -1; first_out = -1; last_out = -1; nxt = 1;
    for (int k = 0; k < 16 + DEPTH + 3; k++) begin
      step(1'b0, 1'b0, (k < 16), 6'(k + 1), 1'b1);
      if (last_acc && k == 0) acc_cyc = k;
      if (obs_dv) begin
        if (first_out < 0) first_out = k;
        last_out = k;
        chk("stream_order", 32'(obs_dd), 32'(nxt));
        nxt++;
      end
    end
    chk("first_accept", 32'(acc_cyc), 32'd0);
    chk("latency", 32'(first_out - acc_cyc), 32'(DEPTH));
    chk("stream_count", 32'(nxt), 32'd17);
    chk("stream_span", 32'(last_out - first_out), 32'd15);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 6'(6'h21 + k), 1'b0);
    step(1'b1, 1'b0, 1'b1, 6'h2F, 1'b1);
    step(1'b1, 1'b0, 1'b1, 6'h2F, 1'b1);
    chk("in_reset_down_valid", 32'(obs_dv), 32'd0);
    chk("in_reset_occ", 32'(obs_occ), 32'd0);
    chk("in_reset_empty", 32'(obs_empty), 32'd1);
    for (int k = 0; k < DEPTH + 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
      chk("no_stale_after_reset", 32'(obs_dv), 32'd0);
    end

    // Full with simultaneous in/out
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 6'(6'h20 + k), 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 6'(6'h30 + k), 1'b1);
      chk("pass_occ", 32'(obs_occ), 32'd4);
      chk("pass_up_ready", 32'(obs_ur), 32'd1);
      chk("pass_order", 32'(obs_dd), (k < 4) ? 32'(6'h20 + k) : 32'(6'h30 + k - 4));
    end
    for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);

    // Flush with occupancy 3
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 6'(6'h11 + k), 1'b0);
    chk("pre_flush_occ", 32'(obs_occ), 32'd2);
    step(1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("pre_flush_occ3", 32'(obs_occ), 32'd3);
    step(1'b0, 1'b1, 1'b1, 6'h3F, 1'b1);
    chk("flush_up_ready", 32'(obs_ur), 32'd0);
    chk("flush_down_valid", 32'(obs_dv), 32'd0);
    step(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    chk("post_flush_occ", 32'(obs_occ), 32'd0);
    for (int k = 0; k < DEPTH + 1; k++) begin
      step(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
      chk("no_word_after_flush", 32'(obs_dv), 32'd0);
    end

    // Random traffic against the model
    for (int k = 0; k < 10000; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < DEPTH + 2; k++) step(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    chk("drained_occ", 32'(obs_occ), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
